// File: rtl/ddr3_block_rd_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_block_rd_cmd_pkg
// Shared constants for the DDR3 block read-command path of the rotation
// pipeline: the DDR3 word-address width, the default burst length and data
// width, and the command FSM state encoding.
// ---------------------------------------------------------------------------
package ddr3_block_rd_cmd_pkg;

    localparam int ADDR_W        = 26;
    localparam int LEN_W         = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_DATA_W    = 64;

    // Command FSM encoding; kept as plain constants so the encoding is visible
    // to older tools and to anyone probing the state register in a netlist.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_LATCH   = 2'd2;
    localparam logic [1:0] S_CMD     = 2'd3;

    typedef logic [ADDR_W-1:0] ddr3_addr_t;

endpackage

// File: rtl/ddr3_block_rd_cmd_if.sv
// ---------------------------------------------------------------------------
// ddr3_block_rd_cmd_if
// Read-command channel towards the DDR3 user command port.
//   cmd_valid : command valid (driven by the requester)
//   cmd_ready : controller accepts the command this cycle
//   cmd_addr  : burst start address
//   cmd_len   : burst length in beats
// master = command issuer, slave = DDR3 controller.
// ---------------------------------------------------------------------------
interface ddr3_block_rd_cmd_if;
    import ddr3_block_rd_cmd_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    ddr3_addr_t       cmd_addr;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/ddr3_rd_credit_tracker.sv
// ---------------------------------------------------------------------------
// ddr3_rd_credit_tracker
// Book-keeping for read bursts in flight: counts outstanding bursts and the
// beat position inside the current block, decides whether another burst may
// be requested, flags the last beat of each block and records data that
// arrives with nothing outstanding.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_fire            : read command handshake this cycle
//   rd_data_valid       : returned beat this cycle
//   pix_fifo_space      : free words in the pixel FIFO
//   credit_ok           : another burst fits (count cap and FIFO space)
//   outstanding_any     : at least one burst in flight
//   block_done          : registered pulse, aligned with the forwarded last beat
//   err_overrun         : sticky, a beat arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ddr3_rd_credit_tracker #(
    parameter int BURST_LEN       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SPACE_W         = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_fire,
    input  logic               rd_data_valid,
    input  logic [SPACE_W-1:0] pix_fifo_space,
    output logic               credit_ok,
    output logic               outstanding_any,
    output logic               block_done,
    output logic               err_overrun
);

    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [OUT_W-1:0]  OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
    localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
    localparam logic [SPACE_W:0]  BURST_WORDS = (SPACE_W + 1)'(BURST_LEN);

    logic [OUT_W-1:0]  outstanding_reg, outstanding_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              block_done_reg;
    logic              err_overrun_reg;

    logic              last_beat;
    logic              none_outstanding;
    logic              retire;
    logic [SPACE_W:0]  need_words;

    always_comb begin
        last_beat        = rd_data_valid && (beat_reg == BEAT_LAST);
        none_outstanding = (outstanding_reg == '0);
        // A last beat with nothing in flight is stray data: it must not
        // pull the counter below zero.
        retire           = last_beat && !none_outstanding;

        // Words the pixel FIFO must hold if every burst in flight plus the
        // next one all land before anything drains; one bit wider than the
        // space count so the product cannot wrap.
        need_words = ((SPACE_W + 1)'(outstanding_reg) + (SPACE_W + 1)'(1)) * BURST_WORDS;
        credit_ok  = (outstanding_reg < OUT_MAX) && ({1'b0, pix_fifo_space} >= need_words);

        outstanding_next = outstanding_reg;
        if (cmd_fire && !retire) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!cmd_fire && retire) begin
            outstanding_next = outstanding_reg - 1'b1;
        end

        // Explicit wrap so non-power-of-two burst lengths also work.
        beat_next = beat_reg;
        if (rd_data_valid) begin
            beat_next = last_beat ? '0 : beat_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
            beat_reg        <= '0;
            block_done_reg  <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            beat_reg        <= beat_next;
            block_done_reg  <= last_beat;
            err_overrun_reg <= err_overrun_reg | (rd_data_valid && none_outstanding);
        end
    end

    assign outstanding_any = !none_outstanding;
    assign block_done      = block_done_reg;
    assign err_overrun     = err_overrun_reg;

endmodule

// File: rtl/ddr3_block_rd_cmd.sv
// ---------------------------------------------------------------------------
// ddr3_block_rd_cmd
// Pops 4x4-pixel block addresses from the (non-FWFT) address FIFO, issues one
// fixed-length DDR3 read burst per address and forwards the returned beats
// into the pixel FIFO. New bursts are only requested while the pixel FIFO is
// guaranteed to absorb every beat already in flight plus the new burst.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   addr_fifo_empty   : address FIFO empty flag (registered upstream)
//   addr_fifo_rd_req  : address FIFO pop, data valid one cycle later
//   addr_fifo_q       : address FIFO read data
//   cmd               : read command channel (master side)
//   rd_data_valid     : DDR3 read beat valid, no back-pressure
//   rd_data           : DDR3 read beat
//   pix_fifo_space    : free words in the pixel FIFO
//   pix_fifo_wr_en    : pixel FIFO write, one cycle after rd_data_valid
//   pix_fifo_wr_data  : pixel FIFO write data
//   block_done        : pulse with the write of the last beat of a block
//   busy              : fetch in progress or bursts in flight
//   err_overrun       : sticky, read data arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ddr3_block_rd_cmd
    import ddr3_block_rd_cmd_pkg::*;
#(
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SPACE_W         = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                addr_fifo_empty,
    output logic                addr_fifo_rd_req,
    input  ddr3_addr_t          addr_fifo_q,
    ddr3_block_rd_cmd_if.master cmd,
    input  logic                rd_data_valid,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic [SPACE_W-1:0]  pix_fifo_space,
    output logic                pix_fifo_wr_en,
    output logic [DATA_W-1:0]   pix_fifo_wr_data,
    output logic                block_done,
    output logic                busy,
    output logic                err_overrun
);

    logic [1:0]        state_reg, state_next;
    logic              rd_req_reg, rd_req_next;
    logic              cmd_valid_reg, cmd_valid_next;
    ddr3_addr_t        cmd_addr_reg, cmd_addr_next;
    logic              wr_en_reg;
    logic [DATA_W-1:0] wr_data_reg;

    logic              cmd_fire;
    logic              credit_ok;
    logic              outstanding_any;

    assign cmd_fire = cmd_valid_reg && cmd.cmd_ready;

    ddr3_rd_credit_tracker #(
        .BURST_LEN       (BURST_LEN),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .SPACE_W         (SPACE_W)
    ) u_credit (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_fire        (cmd_fire),
        .rd_data_valid   (rd_data_valid),
        .pix_fifo_space  (pix_fifo_space),
        .credit_ok       (credit_ok),
        .outstanding_any (outstanding_any),
        .block_done      (block_done),
        .err_overrun     (err_overrun)
    );

    // One address fetch at a time: pop, wait out the FIFO read latency,
    // capture, then hold the command until the controller takes it. Credit
    // is only looked at in S_IDLE, after the previous handshake has already
    // been counted.
    always_comb begin
        state_next     = state_reg;
        rd_req_next    = 1'b0;
        cmd_valid_next = cmd_valid_reg;
        cmd_addr_next  = cmd_addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (!addr_fifo_empty && credit_ok) begin
                    rd_req_next = 1'b1;
                    state_next  = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                state_next = S_LATCH;
            end
            S_LATCH: begin
                cmd_addr_next  = addr_fifo_q;
                cmd_valid_next = 1'b1;
                state_next     = S_CMD;
            end
            S_CMD: begin
                if (cmd.cmd_ready) begin
                    cmd_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next     = S_IDLE;
                cmd_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rd_req_reg    <= 1'b0;
            cmd_valid_reg <= 1'b0;
            cmd_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rd_req_reg    <= rd_req_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_addr_reg  <= cmd_addr_next;
        end
    end

    // Read data is forwarded unconditionally, stray beats included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg   <= rd_data_valid;
            wr_data_reg <= rd_data;
        end
    end

    assign addr_fifo_rd_req = rd_req_reg;
    assign cmd.cmd_valid    = cmd_valid_reg;
    assign cmd.cmd_addr     = cmd_addr_reg;
    assign cmd.cmd_len      = LEN_W'(BURST_LEN);
    assign pix_fifo_wr_en   = wr_en_reg;
    assign pix_fifo_wr_data = wr_data_reg;
    assign busy             = (state_reg != S_IDLE) || outstanding_any;

endmodule

// File: tb/tb_ddr3_block_rd_cmd.sv
// ---------------------------------------------------------------------------
// tb_ddr3_block_rd_cmd
// Bench for ddr3_block_rd_cmd: an address-FIFO model, a DDR3 controller model
// returning one burst per accepted command, and scoreboard monitors for the
// command channel and the pixel-FIFO write side.
// ---------------------------------------------------------------------------
module tb_ddr3_block_rd_cmd;
    import ddr3_block_rd_cmd_pkg::*;

    localparam int BL   = 4;
    localparam int DW   = 64;
    localparam int MAXO = 8;
    localparam int SW   = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          addr_fifo_empty = 1'b1;
    logic          addr_fifo_rd_req;
    logic [25:0]   addr_fifo_q = '0;
    logic          rd_data_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic [SW-1:0] pix_fifo_space = 10'd1023;
    logic          pix_fifo_wr_en;
    logic [DW-1:0] pix_fifo_wr_data;
    logic          block_done;
    logic          busy;
    logic          err_overrun;

    ddr3_block_rd_cmd_if cmd_if();

    ddr3_block_rd_cmd #(
        .BURST_LEN       (BL),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MAXO),
        .SPACE_W         (SW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr_fifo_empty  (addr_fifo_empty),
        .addr_fifo_rd_req (addr_fifo_rd_req),
        .addr_fifo_q      (addr_fifo_q),
        .cmd              (cmd_if),
        .rd_data_valid    (rd_data_valid),
        .rd_data          (rd_data),
        .pix_fifo_space   (pix_fifo_space),
        .pix_fifo_wr_en   (pix_fifo_wr_en),
        .pix_fifo_wr_data (pix_fifo_wr_data),
        .block_done       (block_done),
        .busy             (busy),
        .err_overrun      (err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- address FIFO model (non-FWFT) ----------------
    logic [25:0] addr_mem [0:255];
    int wr_ptr = 0;   // written by stimulus only
    int rd_ptr = 0;   // written by the FIFO model only

    always @(posedge clk) begin
        if (rst_n && addr_fifo_rd_req) begin
            chk_eq("fifo_pop_nonempty", longint'(rd_ptr != wr_ptr), 1);
            if (rd_ptr != wr_ptr) begin
                addr_fifo_q     <= addr_mem[rd_ptr];
                rd_ptr          <= rd_ptr + 1;
                addr_fifo_empty <= (wr_ptr == rd_ptr + 1);
            end
        end else begin
            addr_fifo_empty <= (wr_ptr == rd_ptr);
        end
    end

    task automatic push_addr(input logic [25:0] a);
        addr_mem[wr_ptr] = a;
        wr_ptr++;
    endtask

    // ---------------- command monitor ----------------
    int accepted  = 0;     // command handshakes seen
    int acc_cyc   = -1;
    int n_rdreq   = 0;
    int rdreq_cyc = -100;
    bit cmd_valid_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (addr_fifo_rd_req) begin
                    n_rdreq++;
                    rdreq_cyc = cyc;
                end
                if (cmd_if.cmd_valid && !cmd_valid_prev)
                    chk_eq("pop_to_cmd_valid_cycles", longint'(cyc - rdreq_cyc), 2);
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                    chk_eq("cmd_addr", cmd_if.cmd_addr, addr_mem[accepted]);
                    chk_eq("cmd_len", cmd_if.cmd_len, BL);
                    accepted++;
                    acc_cyc = cyc;
                end
                cmd_valid_prev = cmd_if.cmd_valid;
            end
        end
    end

    // ---------------- controller model / beat driver ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } beat_t;

    beat_t exp_beat_q[$];

    int started       = 0;   // bursts the controller began returning
    int returned      = 0;   // bursts fully returned
    int release_limit = 1 << 30;
    int inject_target = 0;
    int injected      = 0;
    int done_blocks   = 0;   // blocks retired against real outstanding bursts
    int gbeat         = 0;   // every beat ever seen, stray ones included
    int ready_mode    = 1;   // 0 low, 1 high, 2 random, 3 only with a last beat
    int last_beat_cyc = -1;
    int beat_i        = 0;
    bit gap_rand      = 1'b0;
    bit in_burst      = 1'b0;
    bit err_model     = 1'b0;

    initial begin
        bit    drive_beat;
        bit    burst_last;
        bit    last;
        int    outs;
        beat_t e;
        forever begin
            @(posedge clk);
            #1;
            drive_beat = 1'b0;
            burst_last = 1'b0;
            if (rst_n) begin
                if (!in_burst && (accepted - started) > 0 && returned < release_limit) begin
                    in_burst = 1'b1;
                    beat_i   = 0;
                    started++;
                end
                if (in_burst) begin
                    if (!gap_rand || $urandom_range(0, 3) != 0) begin
                        drive_beat = 1'b1;
                        beat_i++;
                        if (beat_i == BL) begin
                            in_burst      = 1'b0;
                            burst_last    = 1'b1;
                            returned++;
                            last_beat_cyc = cyc;
                        end
                    end
                end else if (injected < inject_target) begin
                    drive_beat = 1'b1;
                    injected++;
                end
            end
            rd_data_valid = drive_beat;
            if (drive_beat) begin
                rd_data = {$urandom, $urandom};
                outs = accepted - done_blocks;
                if (outs == 0) err_model = 1'b1;
                last = (gbeat % BL) == (BL - 1);
                gbeat++;
                if (last && outs > 0) done_blocks++;
                e.data = rd_data;
                e.last = last;
                e.err  = err_model;
                exp_beat_q.push_back(e);
            end
            case (ready_mode)
                0:       cmd_if.cmd_ready = 1'b0;
                1:       cmd_if.cmd_ready = 1'b1;
                2:       cmd_if.cmd_ready = 1'($urandom_range(0, 1));
                default: cmd_if.cmd_ready = burst_last;
            endcase
        end
    end

    // ---------------- pixel-FIFO write monitor ----------------
    int n_wr = 0;

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && pix_fifo_wr_en) begin
                n_wr++;
                if (exp_beat_q.size() == 0) begin
                    chk_eq("write_without_beat", 1, 0);
                end else begin
                    e = exp_beat_q.pop_front();
                    chk_eq("wr_data", pix_fifo_wr_data, e.data);
                    chk_eq("block_done", block_done, e.last);
                    chk_eq("err_overrun_at_write", err_overrun, e.err);
                end
            end else if (rst_n && block_done) begin
                chk_eq("block_done_without_write", 1, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        release_limit = 1 << 30;
        while (k < 3000 && (busy || wr_ptr != rd_ptr || exp_beat_q.size() != 0 ||
                            accepted != started || in_burst)) begin
            @(negedge clk);
            k++;
        end
        chk_eq({name, "_drained"}, longint'(k < 3000), 1);
        chk_eq({name, "_busy_low"}, busy, 0);
        tick(1);
    endtask

    task automatic wait_accepted(input int target, input int bound);
        int k;
        k = 0;
        while (accepted < target && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int acc0;
        int rq0;
        int wr0;
        int k;
        int bad;
        logic [25:0] cap;

        // Reset state
        cmd_if.cmd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_rd_req", addr_fifo_rd_req, 0);
        chk_eq("rst_cmd_valid", cmd_if.cmd_valid, 0);
        chk_eq("rst_cmd_addr", cmd_if.cmd_addr, 0);
        chk_eq("rst_cmd_len", cmd_if.cmd_len, BL);
        chk_eq("rst_wr_en", pix_fifo_wr_en, 0);
        chk_eq("rst_wr_data", pix_fifo_wr_data, 0);
        chk_eq("rst_block_done", block_done, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_err", err_overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single block at 0x000100
        rq0 = n_rdreq;
        wr0 = n_wr;
        push_addr(26'h000100);
        drain("single");
        chk_eq("single_rd_reqs", longint'(n_rdreq - rq0), 1);
        chk_eq("single_writes", longint'(n_wr - wr0), BL);
        $display("single block done: cmds=%0d writes=%0d", accepted, n_wr);

        // Outstanding cap: 10 queued, data withheld
        acc0 = accepted;
        rq0 = n_rdreq;
        release_limit = returned;
        for (int i = 0; i < 10; i++) push_addr(26'h001000 + 26'(i * 16));
        tick(80);
        chk_eq("cap_cmds", longint'(accepted - acc0), MAXO);
        chk_eq("cap_rd_reqs", longint'(n_rdreq - rq0), MAXO);
        chk_eq("cap_busy", busy, 1);
        release_limit = returned + 1;
        wait_accepted(acc0 + MAXO + 1, 100);
        chk_eq("cap_ninth_cmd", longint'(accepted - acc0), MAXO + 1);
        chk_eq("cap_ninth_after_block", longint'(acc_cyc > last_beat_cyc), 1);
        drain("cap");
        $display("cap test done: cmds=%0d", accepted - acc0);

        // Pixel-FIFO space: 11 words stop the third burst, 12 let it through
        acc0 = accepted;
        release_limit = returned;
        pix_fifo_space = 10'd11;
        for (int i = 0; i < 3; i++) push_addr(26'h002000 + 26'(i * 4));
        tick(60);
        chk_eq("space11_cmds", longint'(accepted - acc0), 2);
        pix_fifo_space = 10'd12;
        wait_accepted(acc0 + 3, 40);
        chk_eq("space12_cmds", longint'(accepted - acc0), 3);
        drain("space");
        pix_fifo_space = 10'd1023;
        $display("space test done: cmds=%0d", accepted - acc0);

        // cmd_ready held low
        ready_mode = 0;
        rq0 = n_rdreq;
        push_addr(26'h0ABCDE);
        push_addr(26'h012345);
        k = 0;
        while (!cmd_if.cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk_eq("stall_cmd_valid_seen", cmd_if.cmd_valid, 1);
        cap = cmd_if.cmd_addr;
        chk_eq("stall_cmd_addr", cap, addr_mem[accepted]);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cmd_if.cmd_valid || cmd_if.cmd_addr != cap || addr_fifo_rd_req) bad++;
        end
        chk_eq("stall_stable_cycles_bad", longint'(bad), 0);
        chk_eq("stall_rd_reqs", longint'(n_rdreq - rq0), 1);
        ready_mode = 1;
        tick(1);
        drain("stall");
        $display("stall test done: bad cycles=%0d", bad);

        // Handshake coinciding with the last beat of another block
        acc0 = accepted;
        release_limit = returned;
        push_addr(26'h003300);
        wait_accepted(acc0 + 1, 40);
        ready_mode = 0;
        push_addr(26'h003340);
        k = 0;
        while (!cmd_if.cmd_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        ready_mode = 3;
        release_limit = returned + 1;
        wait_accepted(acc0 + 2, 50);
        chk_eq("coincide_cmds", longint'(accepted - acc0), 2);
        chk_eq("coincide_same_cycle", longint'(acc_cyc), longint'(last_beat_cyc));
        ready_mode = 1;
        tick(1);
        drain("coincide");
        chk_eq("coincide_no_err", err_overrun, 0);
        $display("coincide test done: hs cycle=%0d last beat cycle=%0d", acc_cyc, last_beat_cyc);

        // Randomized traffic
        ready_mode = 2;
        gap_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push_addr(26'($urandom));
            tick($urandom_range(0, 6));
        end
        drain("random");
        ready_mode = 1;
        gap_rand = 1'b0;
        $display("random test done: total cmds=%0d writes=%0d", accepted, n_wr);

        // Stray beat with nothing outstanding
        wr0 = n_wr;
        chk_eq("overrun_before", err_overrun, 0);
        inject_target = injected + 1;
        tick(5);
        chk_eq("overrun_set", err_overrun, 1);
        tick(20);
        chk_eq("overrun_sticky", err_overrun, 1);
        chk_eq("overrun_beat_written", longint'(n_wr - wr0), 1);
        drain("overrun");
        $display("overrun test done: err_overrun=%0b", err_overrun);

        chk_eq("scoreboard_empty", longint'(exp_beat_q.size()), 0);
        chk_eq("all_addresses_issued", longint'(accepted), longint'(wr_ptr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
